// File: rtl/gp_pkg.sv
// Shared definitions for the graphics command decoder: opcodes, field positions, FSM states.
package gp_pkg;

    localparam int GP_ADDR_W  = 30;
    localparam int GP_WORD_W  = 32;
    localparam int GP_OP_W    = 8;
    localparam int GP_COLOR_W = 24;
    localparam int GP_COORD_W = 16;

    localparam int GP_OP_MSB  = 31;
    localparam int GP_OP_LSB  = 24;
    localparam int GP_PAY_MSB = 23;
    localparam int GP_PAY_LSB = 0;
    localparam int GP_X_MSB   = 31;
    localparam int GP_X_LSB   = 16;
    localparam int GP_Y_MSB   = 15;
    localparam int GP_Y_LSB   = 0;

    localparam logic [GP_OP_W-1:0] GP_OP_STOP = 8'h00;
    localparam logic [GP_OP_W-1:0] GP_OP_FILL = 8'h01;
    localparam logic [GP_OP_W-1:0] GP_OP_LINE = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DECODE,
        ST_ARG_REQ,
        ST_ARG_WAIT,
        ST_ISSUE_FILL,
        ST_ISSUE_LINE,
        ST_HALT
    } gp_state_t;

endpackage

// File: rtl/gp_point_unpack.sv
// Splits a 32-bit point word into its x (upper half) and y (lower half) coordinates.
import gp_pkg::*;

module gp_point_unpack (
    input  logic [GP_WORD_W-1:0]  word,
    output logic [GP_COORD_W-1:0] x,
    output logic [GP_COORD_W-1:0] y
);

    assign x = word[GP_X_MSB:GP_X_LSB];
    assign y = word[GP_Y_MSB:GP_Y_LSB];

endmodule

// File: rtl/gp_cmd_decoder.sv
// Fetches a command list from memory and hands FILL/LINE commands to the drawing engines.
// Define GP_CMD_ERR_EN to flag unknown opcodes (sticky gp_err, halt) instead of skipping them.
import gp_pkg::*;

module gp_cmd_decoder (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  gp_start,
    input  logic [GP_ADDR_W-1:0]  gp_code_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [GP_ADDR_W-1:0]  mem_req_addr,
    input  logic                  mem_rdata_valid,
    input  logic [GP_WORD_W-1:0]  mem_rdata,
    output logic                  fill_valid,
    input  logic                  fill_ready,
    output logic [GP_COLOR_W-1:0] fill_color,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [GP_COLOR_W-1:0] line_color,
    output logic [GP_COORD_W-1:0] line_x0,
    output logic [GP_COORD_W-1:0] line_y0,
    output logic [GP_COORD_W-1:0] line_x1,
    output logic [GP_COORD_W-1:0] line_y1,
    output logic                  gp_busy,
    output logic                  gp_done,
    output logic                  gp_err
);

    localparam logic [GP_ADDR_W-1:0] PTR_ONE = 1;

    gp_state_t             state_reg, state_next;
    logic [GP_ADDR_W-1:0]  ptr_reg, ptr_next;
    logic [GP_WORD_W-1:0]  cmd_reg, cmd_next;
    logic [GP_COLOR_W-1:0] fill_color_reg, fill_color_next;
    logic [GP_COLOR_W-1:0] line_color_reg, line_color_next;
    logic [GP_COORD_W-1:0] x0_reg, x0_next, y0_reg, y0_next;
    logic [GP_COORD_W-1:0] x1_reg, x1_next, y1_reg, y1_next;
    logic                  arg_sel_reg, arg_sel_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic [GP_COORD_W-1:0] pt_x, pt_y;
    logic [GP_OP_W-1:0]    opcode;
    logic [GP_COLOR_W-1:0] payload;
`ifdef GP_CMD_ERR_EN
    logic                  err_reg, err_next;
`endif

    gp_point_unpack u_point_unpack (
        .word (mem_rdata),
        .x    (pt_x),
        .y    (pt_y)
    );

    assign opcode  = cmd_reg[GP_OP_MSB:GP_OP_LSB];
    assign payload = cmd_reg[GP_PAY_MSB:GP_PAY_LSB];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            cmd_reg        <= '0;
            fill_color_reg <= '0;
            line_color_reg <= '0;
            x0_reg         <= '0;
            y0_reg         <= '0;
            x1_reg         <= '0;
            y1_reg         <= '0;
            arg_sel_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            cmd_reg        <= cmd_next;
            fill_color_reg <= fill_color_next;
            line_color_reg <= line_color_next;
            x0_reg         <= x0_next;
            y0_reg         <= y0_next;
            x1_reg         <= x1_next;
            y1_reg         <= y1_next;
            arg_sel_reg    <= arg_sel_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

`ifdef GP_CMD_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
    assign gp_err = err_reg;
`else
    assign gp_err = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        cmd_next        = cmd_reg;
        fill_color_next = fill_color_reg;
        line_color_next = line_color_reg;
        x0_next         = x0_reg;
        y0_next         = y0_reg;
        x1_next         = x1_reg;
        y1_next         = y1_reg;
        arg_sel_next    = arg_sel_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
`ifdef GP_CMD_ERR_EN
        err_next        = err_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (gp_start) begin
                    ptr_next   = gp_code_addr;
                    busy_next  = 1'b1;
                    state_next = ST_REQ;
`ifdef GP_CMD_ERR_EN
                    err_next   = 1'b0;
`endif
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    ptr_next   = ptr_reg + PTR_ONE;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_rdata_valid) begin
                    cmd_next   = mem_rdata;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    GP_OP_STOP: begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = ST_IDLE;
                    end
                    GP_OP_FILL: begin
                        fill_color_next = payload;
                        state_next      = ST_ISSUE_FILL;
                    end
                    GP_OP_LINE: begin
                        line_color_next = payload;
                        arg_sel_next    = 1'b0;
                        state_next      = ST_ARG_REQ;
                    end
                    default: begin
`ifdef GP_CMD_ERR_EN
                        err_next   = 1'b1;
                        state_next = ST_HALT;
`else
                        state_next = ST_REQ;
`endif
                    end
                endcase
            end
            ST_ARG_REQ: begin
                if (mem_req_ready) begin
                    ptr_next   = ptr_reg + PTR_ONE;
                    state_next = ST_ARG_WAIT;
                end
            end
            ST_ARG_WAIT: begin
                // arg_sel_reg picks which endpoint the returning word belongs to
                if (mem_rdata_valid) begin
                    if (!arg_sel_reg) begin
                        x0_next      = pt_x;
                        y0_next      = pt_y;
                        arg_sel_next = 1'b1;
                        state_next   = ST_ARG_REQ;
                    end else begin
                        x1_next    = pt_x;
                        y1_next    = pt_y;
                        state_next = ST_ISSUE_LINE;
                    end
                end
            end
            ST_ISSUE_FILL: begin
                if (fill_ready) begin
                    state_next = ST_REQ;
                end
            end
            ST_ISSUE_LINE: begin
                if (line_ready) begin
                    state_next = ST_REQ;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign mem_req_valid = (state_reg == ST_REQ) || (state_reg == ST_ARG_REQ);
    assign mem_req_addr  = ptr_reg;
    assign fill_valid    = (state_reg == ST_ISSUE_FILL);
    assign fill_color    = fill_color_reg;
    assign line_valid    = (state_reg == ST_ISSUE_LINE);
    assign line_color    = line_color_reg;
    assign line_x0       = x0_reg;
    assign line_y0       = y0_reg;
    assign line_x1       = x1_reg;
    assign line_y1       = y1_reg;
    assign gp_busy       = busy_reg;
    assign gp_done       = done_reg;

endmodule

// File: tb/tb_gp_cmd_decoder.sv
// Directed bench for gp_cmd_decoder: a list interpreter predicts reads/fills/lines, a monitor compares every cycle.
module tb_gp_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gp_start = 1'b0;
    logic [29:0] gp_code_addr = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [29:0] mem_req_addr;
    logic        mem_rdata_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        fill_valid;
    logic        fill_ready = 1'b1;
    logic [23:0] fill_color;
    logic        line_valid;
    logic        line_ready = 1'b1;
    logic [23:0] line_color;
    logic [15:0] line_x0, line_y0, line_x1, line_y1;
    logic        gp_busy, gp_done, gp_err;

    gp_cmd_decoder dut (
        .clk(clk), .rst(rst), .gp_start(gp_start), .gp_code_addr(gp_code_addr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_color(fill_color),
        .line_valid(line_valid), .line_ready(line_ready), .line_color(line_color),
        .line_x0(line_x0), .line_y0(line_y0), .line_x1(line_x1), .line_y1(line_y1),
        .gp_busy(gp_busy), .gp_done(gp_done), .gp_err(gp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] c;
        logic [15:0] x0, y0, x1, y1;
    } line_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [29:0]];
    logic [29:0] exp_reads [$];
    logic [23:0] exp_fills [$];
    line_t       exp_lines [$];
    bit          exp_done, exp_err;

    int          done_cnt, rd_cnt, fill_stall;
    logic [23:0] last_fill;
    line_t       last_line;
    bit          mem_pend = 1'b0;
    logic [29:0] mem_pend_addr = '0;
    int          fill_hold = 0;
    int          line_hold = 0;
    bit          mem_rand = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic flag_fail(input string name, input logic [127:0] got);
        total++;
        bad++;
        $display("FAIL %s: got %0h expected none", name, got);
    endtask

    // Walk the command list the way the rules describe it and queue the expected traffic.
    task automatic build_model(input logic [29:0] start);
        logic [29:0] p;
        logic [31:0] w;
        line_t       l;
        bit          run;
        exp_reads.delete(); exp_fills.delete(); exp_lines.delete();
        exp_done = 1'b0; exp_err = 1'b0;
        p = start; run = 1'b1;
        for (int n = 0; n < 64 && run; n++) begin
            exp_reads.push_back(p); w = mem[p]; p = p + 1;
            case (w[31:24])
                8'h00: begin exp_done = 1'b1; run = 1'b0; end
                8'h01: exp_fills.push_back(w[23:0]);
                8'h02: begin
                    l.c = w[23:0];
                    exp_reads.push_back(p); w = mem[p]; p = p + 1;
                    l.x0 = w[31:16]; l.y0 = w[15:0];
                    exp_reads.push_back(p); w = mem[p]; p = p + 1;
                    l.x1 = w[31:16]; l.y1 = w[15:0];
                    exp_lines.push_back(l);
                end
                default: begin
`ifdef GP_CMD_ERR_EN
                    exp_err = 1'b1; run = 1'b0;
`endif
                end
            endcase
        end
    endtask

    // Memory and engine responder: inputs change 1 time unit after the rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_rdata_valid = mem_pend || (mem_rand && ($urandom_range(0, 3) == 0));
            mem_rdata       = mem_pend ? mem[mem_pend_addr] : 32'hDEADBEEF;
            mem_req_ready   = mem_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (fill_valid === 1'b1 && fill_hold > 0) begin fill_ready = 1'b0; fill_hold--; end
            else fill_ready = 1'b1;
            if (line_valid === 1'b1 && line_hold > 0) begin line_ready = 1'b0; line_hold--; end
            else line_ready = 1'b1;
        end
    end

    // Cycle monitor: handshakes against the model, plus stability/exclusivity rules.
    initial begin
        bit          pf_v = 0, pf_r = 0, pl_v = 0, pl_r = 0, pm_v = 0, pm_r = 0;
        logic [23:0] pf_c = '0;
        line_t       pl = '0, cur;
        logic [29:0] pm_a = '0;
        forever begin
            @(negedge clk);
            cur = {line_color, line_x0, line_y0, line_x1, line_y1};
            if (rst) begin
                pf_v = 0; pl_v = 0; pm_v = 0; mem_pend = 1'b0;
                continue;
            end
            check("valid_exclusive", fill_valid & line_valid, 0);
            if (pf_v && !pf_r) begin
                check("fill_valid_held", fill_valid, 1);
                check("fill_color_held", fill_color, pf_c);
            end
            if (pl_v && !pl_r) begin
                check("line_valid_held", line_valid, 1);
                check("line_payload_held", cur, pl);
            end
            if (pm_v && !pm_r) begin
                check("req_valid_held", mem_req_valid, 1);
                check("req_addr_held", mem_req_addr, pm_a);
            end
            if (fill_valid || line_valid) check("no_req_while_issuing", mem_req_valid, 0);
            mem_pend = mem_req_valid && mem_req_ready;
            mem_pend_addr = mem_req_addr;
            if (mem_pend) begin
                rd_cnt++;
                if (exp_reads.size() == 0) flag_fail("unexpected_read", mem_req_addr);
                else check("read_addr", mem_req_addr, exp_reads.pop_front());
            end
            if (fill_valid && !fill_ready) fill_stall++;
            if (fill_valid && fill_ready) begin
                last_fill = fill_color;
                if (exp_fills.size() == 0) flag_fail("unexpected_fill", fill_color);
                else check("fill_color", fill_color, exp_fills.pop_front());
            end
            if (line_valid && line_ready) begin
                last_line = cur;
                if (exp_lines.size() == 0) flag_fail("unexpected_line", cur);
                else check("line_payload", cur, exp_lines.pop_front());
            end
            if (gp_done) begin
                done_cnt++;
                check("done_expected", gp_done, exp_done);
                check("busy_at_done", gp_busy, 0);
            end
`ifndef GP_CMD_ERR_EN
            check("err_tied_low", gp_err, 0);
`endif
            pf_v = fill_valid; pf_r = fill_ready; pf_c = fill_color;
            pl_v = line_valid; pl_r = line_ready; pl = cur;
            pm_v = mem_req_valid; pm_r = mem_req_ready; pm_a = mem_req_addr;
        end
    end

    task automatic check_idle_outputs(input string name);
        check({name, "_flags"}, {mem_req_valid, fill_valid, line_valid, gp_busy, gp_done, gp_err}, 0);
        check({name, "_addr"}, mem_req_addr, 0);
        check({name, "_colors"}, {fill_color, line_color}, 0);
        check({name, "_points"}, {line_x0, line_y0, line_x1, line_y1}, 0);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        line_hold = 0; fill_hold = 0;
        exp_reads.delete(); exp_fills.delete(); exp_lines.delete();
        @(negedge clk);
        check_idle_outputs(name);
    endtask

    task automatic start_list(input logic [29:0] addr);
        done_cnt = 0; rd_cnt = 0; fill_stall = 0;
        last_fill = '0; last_line = '0;
        build_model(addr);
        @(posedge clk); #1 gp_start = 1'b1; gp_code_addr = addr;
        @(posedge clk); #1 gp_start = 1'b0; gp_code_addr = '0;
    endtask

    task automatic wait_end(input string name, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (gp_done || gp_err) ok = 1'b1;
        end
        if (!ok) flag_fail({name, "_timeout"}, gp_busy);
        repeat (3) @(negedge clk);
        check({name, "_reads_left"}, exp_reads.size(), 0);
        check({name, "_fills_left"}, exp_fills.size(), 0);
        check({name, "_lines_left"}, exp_lines.size(), 0);
        check({name, "_done_count"}, done_cnt, exp_done);
        check({name, "_busy_end"}, gp_busy, exp_err);
    endtask

    task automatic wait_signal(input string name, input bit is_line, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (is_line ? line_valid : fill_valid) ok = 1'b1;
        end
        if (!ok) flag_fail({name, "_timeout"}, gp_busy);
    endtask

    initial begin
        do_reset("reset");

        // A: single fill then stop
        mem[30'h100] = 32'h01FFFFFF; mem[30'h101] = 32'h00000000;
        start_list(30'h100);
        wait_end("A", 200);
        check("A_fill_literal", last_fill, 24'hFFFFFF);
        check("A_read_count", rd_cnt, 2);

        // B: line with two point words, memory ready randomised
        mem_rand = 1'b1;
        mem[30'h200] = 32'h02FF0000; mem[30'h201] = 32'h00000000;
        mem[30'h202] = 32'h02580320; mem[30'h203] = 32'h00000000;
        start_list(30'h200);
        wait_end("B", 400);
        check("B_line_literal", last_line, {24'hFF0000, 16'd0, 16'd0, 16'd600, 16'd800});
        check("B_read_count", rd_cnt, 4);
        mem_rand = 1'b0;

        // C/D: stalled fill engine, plus an ignored gp_start while busy
        mem[30'h300] = 32'h01123456; mem[30'h301] = 32'h00000000;
        fill_hold = 5;
        start_list(30'h300);
        wait_signal("C_fill", 1'b0, 100);
        @(posedge clk); #1 gp_start = 1'b1; gp_code_addr = 30'h1234;
        @(posedge clk); #1 gp_start = 1'b0; gp_code_addr = '0;
        wait_end("C", 200);
        check("C_stall_cycles", fill_stall, 5);
        check("C_fill_literal", last_fill, 24'h123456);
        check("D_read_count", rd_cnt, 2);

        // E: reset while a line waits on the engine, then a normal run
        mem[30'h400] = 32'h0200FF00; mem[30'h401] = 32'h00010002;
        mem[30'h402] = 32'h00030004; mem[30'h403] = 32'h00000000;
        line_hold = 1000;
        start_list(30'h400);
        wait_signal("E_line", 1'b1, 100);
        @(negedge clk); @(negedge clk);
        check("E_line_waiting", line_valid, 1);
        check("E_line_color", line_color, 24'h00FF00);
        do_reset("E_reset");
        start_list(30'h100);
        wait_end("E_rerun", 200);
        check("E_rerun_fill", last_fill, 24'hFFFFFF);

        // F: unknown opcode
        mem[30'h500] = 32'h07000000; mem[30'h501] = 32'h01ABCDEF; mem[30'h502] = 32'h00000000;
        start_list(30'h500);
        wait_end("F", 200);
`ifdef GP_CMD_ERR_EN
        check("F_err_set", gp_err, 1);
        repeat (10) @(negedge clk);
        check("F_halt_busy", gp_busy, 1);
        check("F_halt_err", gp_err, 1);
        check("F_read_count", rd_cnt, 1);
        do_reset("F_reset");
`else
        check("F_err_low", gp_err, 0);
        check("F_next_fill", last_fill, 24'hABCDEF);
        check("F_read_count", rd_cnt, 3);
`endif

        // W: pointer wraps from the top of the address space to 0
        mem[30'h3FFFFFFF] = 32'h01000001; mem[30'h0] = 32'h00000000;
        start_list(30'h3FFFFFFF);
        wait_end("W", 200);
        check("W_fill_literal", last_fill, 24'h000001);
        check("W_read_count", rd_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gp_cmd_decoder.md
GP_CMD_DECODER -- requirements
Module: gp_cmd_decoder

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- gp_start  in  1  one-cycle pulse that starts a command list.
- gp_code_addr  in  30  word address of the first command word.
- mem_req_valid  out  1  read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  30  word address of the read.
- mem_rdata_valid  in  1  read data returned.
- mem_rdata  in  32  read data word.
- fill_valid  out  1  fill command offered to the engine.
- fill_ready  in  1  fill engine accepts the command.
- fill_color  out  24  fill RGB value.
- line_valid  out  1  line command offered to the engine.
- line_ready  in  1  line engine accepts the command.
- line_color  out  24  line RGB value.
- line_x0, line_y0, line_x1, line_y1  out  16 each  line endpoints.
- gp_busy  out  1  command list in progress.
- gp_done  out  1  one-cycle pulse when a STOP word is decoded.
- gp_err  out  1  sticky flag for an unknown opcode (see REQ-014).

Function
REQ-002 SHALL treat each command word as opcode [31:24] plus payload [23:0]: 0x00 STOP, 0x01 FILL (color = [23:0]), 0x02 LINE (color = [23:0], followed by two point words).
REQ-003 SHALL decode a point word as x = [31:16] and y = [15:0], passed through without clipping.
REQ-004 SHALL implement the states IDLE, REQ, WAIT, DECODE, ARG_REQ, ARG_WAIT, ISSUE_FILL, ISSUE_LINE and HALT.
REQ-005 SHALL react to gp_start only in IDLE: latch gp_code_addr as the pointer, raise gp_busy, and enter REQ on the next cycle; gp_start in any other state SHALL be ignored.
REQ-006 SHALL hold mem_req_valid and mem_req_addr stable in REQ/ARG_REQ until mem_req_ready; the handshake completes in the cycle where both are high, the pointer then increments by 1, and the FSM moves to WAIT/ARG_WAIT.
REQ-007 SHALL keep at most one read outstanding; mem_rdata is captured only in WAIT/ARG_WAIT, and mem_rdata_valid in any other state SHALL be ignored.
REQ-008 On FILL, SHALL present fill_valid with a stable fill_color until fill_ready, then return to REQ; the minimum latency from captured data to fill_valid is 1 cycle.
REQ-009 On LINE, SHALL fetch point 0 then point 1 through ARG_REQ/ARG_WAIT, then assert line_valid with all payload stable until line_ready, then return to REQ.
REQ-010 On STOP, SHALL pulse gp_done for one cycle, drop gp_busy in the same cycle, and return to IDLE.
REQ-011 fill_valid and line_valid SHALL never be high in the same cycle; the valid signals SHALL never deassert before their handshake completes.
REQ-012 The pointer SHALL wrap modulo 2^30 with no error.

Reset
REQ-013 rst SHALL, in any state including mid-handshake, force IDLE on the next edge with the following values: all valid outputs 0, gp_busy 0, gp_done 0, gp_err 0, pointer 0, payload registers 0. A read still in flight at reset SHALL be dropped.

Configuration
REQ-014 Macro GP_CMD_ERR_EN:
- Defined: an unknown opcode sets gp_err, which stays set until the next accepted gp_start or rst, and moves the FSM to HALT. HALT keeps gp_busy 1 and leaves only on rst.
- Undefined: an unknown opcode is skipped as a one-word NOP, and gp_err is tied to 0.

Structure
REQ-015 A shared package gp_pkg SHALL hold the opcode constants (GP_OP_STOP, GP_OP_FILL, GP_OP_LINE), the FSM state enum, and the field bit positions.
REQ-016 A sub-module gp_point_unpack SHALL split a 32-bit point word into x/y.

Verification
REQ-017 The bench SHALL cover the following directed scenarios:
- List {0x01FFFFFF, 0x00000000} at 0x100, memory ready always -> one fill with color FFFFFF, then gp_done; reads issued at addresses 0x100 and 0x101 only.
- List {0x02FF0000, 0x00000000, 0x02580320, 0x00000000} -> line color FF0000, (x0,y0) = (0,0), (x1,y1) = (600,800), then gp_done.
- fill_ready held low for 5 cycles -> fill_valid and fill_color stable for 5 cycles, with no memory request issued meanwhile.
- gp_start pulsed while gp_busy is high -> ignored, and the pointer is unchanged.
- rst asserted while line_valid waits on line_ready -> next cycle all outputs are 0 and the state is IDLE; a later gp_start runs normally.
- Word 0x07000000 -> gp_err = 1 and halt with GP_CMD_ERR_EN; skipped and the next word decoded without it.
